// File: rtl/snoop_blk_sel_arb_md_if.sv
// Snoop lookup bus: per-channel request side and the single response side.
`ifndef ASSOC_LV1
`define ASSOC_LV1 4
`endif
`ifndef ASSOC_WID_LV1
`define ASSOC_WID_LV1 2
`endif

interface snoop_blk_sel_arb_md_if #(
  parameter int ASSOC     = `ASSOC_LV1,
  parameter int ASSOC_WID = `ASSOC_WID_LV1,
  parameter int NUM_CH    = 4,
  parameter int CH_WID    = 2
);
  logic [NUM_CH-1:0]       snp_req_valid;
  logic [NUM_CH*ASSOC-1:0] snp_match_vec;
  logic [NUM_CH-1:0]       snp_req_ready;
  logic                    snp_rsp_valid;
  logic                    snp_rsp_ready;
  logic                    blk_hit_snoop;
  logic [ASSOC_WID-1:0]    blk_access_snoop;
  logic [CH_WID-1:0]       snp_ch_id;
  logic                    multi_hit;
  logic [7:0]              multi_hit_cnt;

  // Requesters and the snoop controller
  modport master (
    output snp_req_valid, snp_match_vec, snp_rsp_ready,
    input  snp_req_ready, snp_rsp_valid, blk_hit_snoop, blk_access_snoop,
           snp_ch_id, multi_hit, multi_hit_cnt
  );

  // Arbiter / encoder / response queue
  modport slave (
    input  snp_req_valid, snp_match_vec, snp_rsp_ready,
    output snp_req_ready, snp_rsp_valid, blk_hit_snoop, blk_access_snoop,
           snp_ch_id, multi_hit, multi_hit_cnt
  );
endinterface

// File: rtl/snoop_blk_sel_arb_md.sv
// Multi-channel snoop way-select: round-robin arbitration over snoop lookups,
// way/hit/multi-hit encoding, a small response FIFO and a multi-hit counter.
`ifndef ASSOC_LV1
`define ASSOC_LV1 4
`endif
`ifndef ASSOC_WID_LV1
`define ASSOC_WID_LV1 2
`endif

module snoop_blk_sel_arb_md #(
  parameter int ASSOC      = `ASSOC_LV1,
  parameter int ASSOC_WID  = `ASSOC_WID_LV1,
  parameter int NUM_CH     = 4,
  parameter int CH_WID     = 2,
  parameter int FIFO_DEPTH = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  snoop_blk_sel_arb_md_if.slave  bus
);
  localparam int PTR_WID = $clog2(FIFO_DEPTH);
  localparam int ENT_WID = ASSOC_WID + CH_WID + 2;
  localparam logic [PTR_WID:0] FULL_CNT = (PTR_WID+1)'(FIFO_DEPTH);

  // Highest matching way wins; an all-zero vector encodes as way 0 like the legacy decoder.
  function automatic logic [ASSOC_WID-1:0] way_enc(input logic [ASSOC-1:0] vec);
    way_enc = '0;
    for (int i = 0; i < ASSOC; i++) begin
      if (vec[i]) way_enc = ASSOC_WID'(i);
      else        way_enc = way_enc;
    end
  endfunction

  // More than one way matching is a coherence violation.
  function automatic logic multi_det(input logic [ASSOC-1:0] vec);
    int cnt;
    cnt = 0;
    for (int i = 0; i < ASSOC; i++) cnt += int'(vec[i]);
    multi_det = (cnt > 1);
  endfunction

  logic [CH_WID-1:0]  rr_ptr_r;
  logic [PTR_WID-1:0] wr_ptr_r;
  logic [PTR_WID-1:0] rd_ptr_r;
  logic [PTR_WID:0]   fifo_count_r;
  logic [ENT_WID-1:0] mem_r [FIFO_DEPTH];
  logic [7:0]         mh_cnt_r;

  logic               full_s;
  logic               grant_vld_s;
  logic [CH_WID-1:0]  grant_idx_s;
  logic [ASSOC-1:0]   grant_vec_s;
  logic [ENT_WID-1:0] new_ent_s;
  logic [ENT_WID-1:0] head_s;
  logic               push_s;
  logic               pop_s;
  logic               rsp_vld_s;
  int                 idx_s;

  assign full_s      = (fifo_count_r == FULL_CNT);
  assign rsp_vld_s   = (fifo_count_r != '0);
  assign grant_vec_s = bus.snp_match_vec[int'(grant_idx_s)*ASSOC +: ASSOC];
  assign new_ent_s   = {|grant_vec_s, way_enc(grant_vec_s), grant_idx_s, multi_det(grant_vec_s)};
  assign push_s      = grant_vld_s;
  assign pop_s       = rsp_vld_s & bus.snp_rsp_ready;
  assign head_s      = mem_r[rd_ptr_r];

  // Round-robin search from rr_ptr; a full queue (pop not considered) blocks every grant.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    idx_s       = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_s = (int'(rr_ptr_r) + k) % NUM_CH;
      if (!grant_vld_s && bus.snp_req_valid[idx_s]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = CH_WID'(idx_s);
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
    if (full_s) grant_vld_s = 1'b0;
    else        grant_vld_s = grant_vld_s;
  end

  // One-hot accept toward the granted requester.
  always_comb begin
    if (grant_vld_s) bus.snp_req_ready = NUM_CH'(1) << grant_idx_s;
    else             bus.snp_req_ready = '0;
  end

  // Response FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      fifo_count_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= new_ent_s;
        wr_ptr_r        <= wr_ptr_r + PTR_WID'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_WID'(1);
      case ({push_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + (PTR_WID+1)'(1);
        2'b01:   fifo_count_r <= fifo_count_r - (PTR_WID+1)'(1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // Round-robin pointer moves past the channel just served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (push_s) begin
      rr_ptr_r <= (grant_idx_s == CH_WID'(NUM_CH-1)) ? '0 : grant_idx_s + CH_WID'(1);
    end
  end

  // Saturating count of accepted multi-hit lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mh_cnt_r <= 8'd0;
    end else if (push_s && new_ent_s[0] && (mh_cnt_r != 8'hFF)) begin
      mh_cnt_r <= mh_cnt_r + 8'd1;
    end
  end

  assign bus.multi_hit_cnt = mh_cnt_r;
  assign bus.snp_rsp_valid = rsp_vld_s;

  // Head fields are forced to zero while the queue is empty.
  always_comb begin
    if (rsp_vld_s) begin
      bus.blk_hit_snoop    = head_s[ENT_WID-1];
      bus.blk_access_snoop = head_s[ENT_WID-2 -: ASSOC_WID];
      bus.snp_ch_id        = head_s[CH_WID:1];
      bus.multi_hit        = head_s[0];
    end else begin
      bus.blk_hit_snoop    = 1'b0;
      bus.blk_access_snoop = '0;
      bus.snp_ch_id        = '0;
      bus.multi_hit        = 1'b0;
    end
  end
endmodule

// File: tb/tb_snoop_blk_sel_arb_md.sv
// Randomized scoreboard bench for snoop_blk_sel_arb_md (ASSOC=4, NUM_CH=4, FIFO_DEPTH=2).
module tb_snoop_blk_sel_arb_md;
  localparam int ASSOC = 4;
  localparam int NUM_CH = 4;
  localparam int DEPTH = 2;

  typedef struct {
    logic       hit;
    logic [1:0] way;
    logic [1:0] ch;
    logic       multi;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_CH-1:0]       req_valid;
  logic [NUM_CH*ASSOC-1:0] req_vec;

  exp_t sb[$];
  int   rr_m;
  int   cnt_m;
  int   n_chk = 0;
  int   n_fail = 0;

  snoop_blk_sel_arb_md_if #(.ASSOC(4), .ASSOC_WID(2), .NUM_CH(4), .CH_WID(2)) bus ();

  snoop_blk_sel_arb_md #(.ASSOC(4), .ASSOC_WID(2), .NUM_CH(4), .CH_WID(2), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  assign bus.snp_req_valid = req_valid;
  assign bus.snp_match_vec = req_vec;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding straight from the rules: floor(log2(v)), popcount, non-zero.
  function automatic exp_t model(input logic [3:0] v, input int ch);
    exp_t e;
    int t, w;
    t = int'(v);
    w = 0;
    while (t > 1) begin
      t = t >> 1;
      w++;
    end
    e.hit   = (v != 4'd0);
    e.way   = 2'(w);
    e.ch    = 2'(ch);
    e.multi = ($countones(v) > 1);
    return e;
  endfunction

  // One clock cycle: called at posedge+1 with inputs already driven.
  task automatic step();
    int g;
    logic [3:0] exp_rdy;
    #1;
    g = -1;
    if (sb.size() < DEPTH) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (g < 0 && req_valid[(rr_m + k) % NUM_CH]) g = (rr_m + k) % NUM_CH;
      end
    end
    exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
    chk("req_ready", 32'(bus.snp_req_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    if (g >= 0) begin
      exp_t e;
      e = model(req_vec[g*ASSOC +: ASSOC], g);
      sb.push_back(e);
      rr_m = (g + 1) % NUM_CH;
      if (e.multi && cnt_m < 255) cnt_m++;
      req_valid[g] = 1'b0;
    end
  endtask

  task automatic raise(input int c, input logic [3:0] v);
    req_valid[c] = 1'b1;
    req_vec[c*ASSOC +: ASSOC] = v;
  endtask

  // Idle channels start a new request with probability pct/100.
  task automatic refill(input int pct);
    for (int c = 0; c < NUM_CH; c++) begin
      if (!req_valid[c] && ($urandom_range(99, 0) < 32'(pct))) raise(c, 4'($urandom_range(15, 0)));
    end
  endtask

  task automatic drain();
    req_valid = '0;
    bus.snp_rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (sb.size() != 0) step();
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compares the presented head against the scoreboard front every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        chk("rsp_valid", 32'(bus.snp_rsp_valid), 32'(sb.size() != 0));
        chk("multi_hit_cnt", 32'(bus.multi_hit_cnt), 32'(cnt_m));
        if (bus.snp_rsp_valid && sb.size() != 0) begin
          chk("hit", 32'(bus.blk_hit_snoop), 32'(sb[0].hit));
          chk("way", 32'(bus.blk_access_snoop), 32'(sb[0].way));
          chk("ch_id", 32'(bus.snp_ch_id), 32'(sb[0].ch));
          chk("multi", 32'(bus.multi_hit), 32'(sb[0].multi));
          if (bus.snp_rsp_ready) void'(sb.pop_front());
        end else if (!bus.snp_rsp_valid) begin
          chk("idle_zero", 32'({bus.blk_hit_snoop, bus.blk_access_snoop, bus.snp_ch_id, bus.multi_hit}), 32'd0);
        end
      end
    end
  end

  initial begin
    rr_m = 0;
    cnt_m = 0;
    req_valid = '0;
    req_vec = '0;
    bus.snp_rsp_ready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.snp_rsp_valid), 32'd0);
    chk("rst_cnt", 32'(bus.multi_hit_cnt), 32'd0);
    chk("rst_head", 32'({bus.blk_hit_snoop, bus.blk_access_snoop, bus.snp_ch_id, bus.multi_hit}), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request on channel 2.
    raise(2, 4'b0100);
    bus.snp_rsp_ready = 1'b1;
    step();
    step();

    // All channels busy, continuous consume: strict rotation.
    for (int i = 0; i < 10; i++) begin
      refill(100);
      step();
    end
    drain();

    // Multi-hit on channel 1 until the counter saturates.
    for (int i = 0; i < 300; i++) begin
      raise(1, 4'b1010);
      step();
    end
    drain();
    chk("cnt_sat", 32'(bus.multi_hit_cnt), 32'd255);

    // Miss on channel 0.
    for (int i = 0; i < 3; i++) begin
      raise(0, 4'b0000);
      step();
    end
    drain();

    // Back-pressure with three requesters, then release one pop.
    bus.snp_rsp_ready = 1'b0;
    raise(0, 4'b0001);
    raise(1, 4'b0110);
    raise(2, 4'b1000);
    repeat (4) step();
    chk("bp_queued", 32'(sb.size()), 32'd2);
    bus.snp_rsp_ready = 1'b1;
    step();
    step();
    drain();

    // Reset with two queued entries.
    bus.snp_rsp_ready = 1'b0;
    raise(1, 4'b0010);
    raise(3, 4'b1100);
    step();
    step();
    chk("pre_rst_queued", 32'(sb.size()), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.snp_rsp_valid), 32'd0);
    chk("mid_rst_head", 32'({bus.blk_hit_snoop, bus.blk_access_snoop, bus.snp_ch_id, bus.multi_hit}), 32'd0);
    chk("mid_rst_cnt", 32'(bus.multi_hit_cnt), 32'd0);
    sb.delete();
    rr_m = 0;
    cnt_m = 0;
    req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.snp_rsp_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) raise(c, 4'(c + 1));
    step();
    for (int i = 0; i < 4; i++) step();
    drain();

    // Fully random traffic.
    for (int i = 0; i < 600; i++) begin
      refill(40);
      bus.snp_rsp_ready = ($urandom_range(3, 0) != 0);
      step();
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
